// File: rtl/lfo_pkg.sv
// Shared definitions for the LFO sine driver: FSM state encoding,
// the IEEE-754 single-precision exponent bias and default phase constants.
package lfo_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    OUTPUT  = 3'd4
  } lfoState_t;

  localparam int FLOAT_BIAS   = 127;
  localparam int PHASE_W_DEF  = 24;
  localparam int FRAC_W_DEF   = 21;
  localparam int TWO_PI_Q_DEF = 13176795;

endpackage

// File: rtl/lfo_sin_driver_if.sv
// Start/done handshake between the LFO driver (master) and the pipelined
// sin unit (slave). The driver issues a one-cycle start with a float phase,
// the sin unit answers with a one-cycle done and the float result.
interface lfo_sin_driver_if;

  logic        sin_start;
  logic [31:0] sin_data;
  logic [31:0] sin_result;
  logic        sin_done;

  modport master (
    output sin_start,
    output sin_data,
    input  sin_result,
    input  sin_done
  );

  modport slave (
    input  sin_start,
    input  sin_data,
    output sin_result,
    output sin_done
  );

endinterface

// File: rtl/fix2float_u24.sv
// Combinational unsigned 24-bit fixed-point to IEEE-754 single converter.
// A 24-bit value always fits the 24-bit significand, so the result is exact
// and no rounding is needed. Zero maps to +0.0.
module fix2float_u24
  import lfo_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
)(
  input  logic [23:0] i_fix,
  output logic [31:0] o_float
);

  logic [4:0]  w_msb;
  logic [7:0]  w_exp;
  logic [22:0] w_man;

  // Priority encoder: later (higher) set bits overwrite earlier ones, so the MSB wins
  always_comb begin
    w_msb = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (i_fix[i]) begin
        w_msb = 5'(i);
      end
    end
  end

  // Normalise so the leading one drops off as the hidden bit, then pack the fields
  always_comb begin
    w_man   = 23'(i_fix << (5'd23 - w_msb));
    w_exp   = 8'(FLOAT_BIAS + int'(w_msb) - FRAC_W);
    o_float = (i_fix == 24'd0) ? 32'd0 : {1'b0, w_exp, w_man};
  end

endmodule

// File: rtl/lfo_sin_driver.sv
// LFO sine driver: a Q3.21 radian phase accumulator wrapped at 2*pi, advanced
// on every audio sample tick. Each accepted tick converts the phase to float,
// issues one request to the sin unit, waits for done and presents the result
// with a one-cycle valid strobe. Ticks arriving while busy are dropped and
// flagged in the sticky overrun bit.
// Optional build macro LFO_TIMEOUT_EN adds a WAIT watchdog with a sticky
// timeout_err output; without it WAIT waits indefinitely.
module lfo_sin_driver
  import lfo_pkg::*;
#(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int TWO_PI_Q = TWO_PI_Q_DEF
`ifdef LFO_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] phase_inc,
  lfo_sin_driver_if.master   sinBus,
  output logic [31:0]        lfo_out,
  output logic               lfo_valid,
  output logic               busy,
  output logic               overrun
`ifdef LFO_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  localparam int SUM_W = PHASE_W + 1;
  localparam logic [PHASE_W-1:0] INC_MAX  = PHASE_W'(TWO_PI_Q - 1);
  localparam logic [SUM_W-1:0]   TWO_PI_X = SUM_W'(TWO_PI_Q);

  lfoState_t r_state;
  lfoState_t w_nextState;

  logic [PHASE_W-1:0] r_phase;
  logic [31:0]        r_sinData;
  logic [31:0]        r_lfoOut;
  logic               r_overrun;

  logic [PHASE_W-1:0] w_incC;
  logic [SUM_W-1:0]   w_sum;
  logic [PHASE_W-1:0] w_nextPhase;
  logic [31:0]        w_phaseFloat;
  logic               w_timeoutHit;
  logic               w_sinStart;
  logic               w_lfoValid;
  logic               w_busy;

  fix2float_u24 #(
    .FRAC_W (FRAC_W)
  ) u_fix2float (
    .i_fix   (r_phase),
    .o_float (w_phaseFloat)
  );

`ifdef LFO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_waitCnt;
  logic             r_timeoutErr;

  assign w_timeoutHit = (r_state == WAIT) && !sinBus.sin_done &&
                        (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: count cycles spent in WAIT and latch a sticky error when it expires
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_waitCnt    <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      if (r_state == WAIT) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end else begin
        r_waitCnt <= '0;
      end
      if (w_timeoutHit) begin
        r_timeoutErr <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeoutErr;
`else
  assign w_timeoutHit = 1'b0;
`endif

  // Clamp the increment below 2*pi so a single subtraction always re-wraps the phase
  always_comb begin
    w_incC      = (phase_inc > INC_MAX) ? INC_MAX : phase_inc;
    w_sum       = {1'b0, r_phase} + {1'b0, w_incC};
    w_nextPhase = (w_sum >= TWO_PI_X) ? PHASE_W'(w_sum - TWO_PI_X) : w_sum[PHASE_W-1:0];
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state: one request per accepted tick, done only honoured in WAIT
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (sample_tick) w_nextState = CONVERT;
      CONVERT: w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT: begin
        if (sinBus.sin_done) begin
          w_nextState = OUTPUT;
        end else if (w_timeoutHit) begin
          w_nextState = IDLE;
        end
      end
      OUTPUT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs are pure functions of the current state
  always_comb begin
    w_sinStart = (r_state == ISSUE);
    w_lfoValid = (r_state == OUTPUT);
    w_busy     = (r_state != IDLE);
  end

  // Datapath: phase advances on every tick regardless of state; payload registers follow the FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase   <= '0;
      r_sinData <= 32'd0;
      r_lfoOut  <= 32'd0;
      r_overrun <= 1'b0;
    end else begin
      if (sample_tick) begin
        r_phase <= w_nextPhase;
      end
      if (r_state == CONVERT) begin
        r_sinData <= w_phaseFloat;
      end
      if ((r_state == WAIT) && sinBus.sin_done) begin
        r_lfoOut <= sinBus.sin_result;
      end
      if (sample_tick && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign sinBus.sin_start = w_sinStart;
  assign sinBus.sin_data  = r_sinData;
  assign lfo_out          = r_lfoOut;
  assign lfo_valid        = w_lfoValid;
  assign busy             = w_busy;
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_lfo_sin_driver.sv
// Self-checking bench for lfo_sin_driver. The stimulus side predicts every
// sin request and LFO sample from a plain-arithmetic phase model and pushes
// them into queues; a sin-unit stub answers requests with a chosen latency;
// an independent monitor pops and compares whenever the DUT strobes.
// Build with LFO_TIMEOUT_EN defined to also exercise the WAIT watchdog.
module tb_lfo_sin_driver;

  localparam int unsigned TWO_PI = 13176795;
  localparam int          FRAC   = 21;
`ifdef LFO_TIMEOUT_EN
  localparam int          TIMEOUT = 64;
`endif

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] res;
  } stub_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        sampleTick;
  logic [23:0] phaseInc;
  logic [31:0] lfoOut;
  logic        lfoValid;
  logic        busy;
  logic        overrun;
`ifdef LFO_TIMEOUT_EN
  logic        timeoutErr;
`endif

  lfo_sin_driver_if sinBus ();

  lfo_sin_driver dut (
    .clock       (clock),
    .reset       (reset),
    .sample_tick (sampleTick),
    .phase_inc   (phaseInc),
    .sinBus      (sinBus),
    .lfo_out     (lfoOut),
    .lfo_valid   (lfoValid),
    .busy        (busy),
    .overrun     (overrun)
`ifdef LFO_TIMEOUT_EN
    ,
    .timeout_err (timeoutErr)
`endif
  );

  exp_t  expStartQ[$];
  exp_t  expValidQ[$];
  stub_t stubQ[$];

  int          nVec = 0;
  int          nMis = 0;
  int          cyc = 0;
  int          startSeen = 0;
  int          seenBefore;
  int unsigned modelPhase = 0;
  logic        modelOverrun = 1'b0;
  int          nextFree = 0;
  int          stubRemain = -1;
  logic [31:0] stubResult = 32'd0;
  logic [23:0] rndInc;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference conversion via the simulator's double format: exact for 24 significant bits
  function automatic logic [31:0] toFloat(input int unsigned ph);
    real         r;
    logic [63:0] d;
    logic [10:0] e;
    if (ph == 0) return 32'd0;
    r = real'(ph) / (2.0 ** FRAC);
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {1'b0, e[7:0], d[51:29]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One sample tick; lat==0 means the stub never answers
  task automatic applyStimulus(input logic [23:0] inc, input int lat, input logic [31:0] res);
    int unsigned incC;
    exp_t        e;
    stub_t       s;
    @(negedge clock);
    phaseInc   = inc;
    sampleTick = 1'b1;
    incC       = (int'(inc) > int'(TWO_PI - 1)) ? TWO_PI - 1 : int'(inc);
    modelPhase = (modelPhase + incC) % TWO_PI;
    if (cyc >= nextFree) begin
      e.data = toFloat(modelPhase);
      e.cyc  = cyc + 2;
      expStartQ.push_back(e);
      s.lat = lat;
      s.res = res;
      stubQ.push_back(s);
      if (lat > 0) begin
        e.data = res;
        e.cyc  = cyc + 3 + lat;
        expValidQ.push_back(e);
        nextFree = cyc + 4 + lat;
      end else begin
`ifdef LFO_TIMEOUT_EN
        nextFree = cyc + 3 + TIMEOUT;
`else
        nextFree = 32'h7fffffff;
`endif
      end
    end else begin
      modelOverrun = 1'b1;
    end
    @(negedge clock);
    sampleTick = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset        = 1'b1;
    sampleTick   = 1'b0;
    sinBus.sin_done = 1'b0;
    stubRemain   = -1;
    expStartQ.delete();
    expValidQ.delete();
    stubQ.delete();
    modelPhase   = 0;
    modelOverrun = 1'b0;
    nextFree     = 0;
    #1;
    checkOutput("reset sin_start", {31'd0, sinBus.sin_start}, 32'd0);
    checkOutput("reset sin_data", sinBus.sin_data, 32'd0);
    checkOutput("reset lfo_out", lfoOut, 32'd0);
    checkOutput("reset lfo_valid", {31'd0, lfoValid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset overrun", {31'd0, overrun}, 32'd0);
`ifdef LFO_TIMEOUT_EN
    checkOutput("reset timeout_err", {31'd0, timeoutErr}, 32'd0);
`endif
    idle(2);
    reset = 1'b0;
  endtask

  // Sin unit stub: answers each request after the latency the stimulus chose
  initial begin : stub
    stub_t s;
    sinBus.sin_done   = 1'b0;
    sinBus.sin_result = 32'd0;
    forever begin
      @(negedge clock);
      sinBus.sin_done = 1'b0;
      if (stubRemain > 0) begin
        stubRemain--;
        if (stubRemain == 0) begin
          sinBus.sin_done   = 1'b1;
          sinBus.sin_result = stubResult;
          stubRemain        = -1;
        end
      end
      if (sinBus.sin_start && (stubQ.size() > 0)) begin
        s          = stubQ.pop_front();
        stubResult = s.res;
        stubRemain = (s.lat > 0) ? s.lat : -1;
      end
    end
  end

  // Monitor: compare every DUT strobe against the head of the matching queue
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (sinBus.sin_start) begin
        startSeen++;
        checkOutput("start with done", {31'd0, sinBus.sin_done}, 32'd0);
        if (expStartQ.size() == 0) begin
          checkOutput("unexpected sin_start", {31'd0, sinBus.sin_start}, 32'd0);
        end else begin
          e = expStartQ.pop_front();
          checkOutput("sin_data", sinBus.sin_data, e.data);
          checkOutput("sin_start cycle", cyc, e.cyc);
        end
      end
      if (lfoValid) begin
        if (expValidQ.size() == 0) begin
          checkOutput("unexpected lfo_valid", {31'd0, lfoValid}, 32'd0);
        end else begin
          e = expValidQ.pop_front();
          checkOutput("lfo_out", lfoOut, e.data);
          checkOutput("lfo_valid cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    reset      = 1'b1;
    sampleTick = 1'b0;
    phaseInc   = 24'd0;
    doReset();

    $display("[TB] zero increment");
    repeat (3) begin
      applyStimulus(24'd0, 3, $urandom);
      idle(15);
    end
    checkOutput("overrun zero inc", {31'd0, overrun}, {31'd0, modelOverrun});

    $display("[TB] one radian per tick");
    doReset();
    applyStimulus(24'd2097152, 5, $urandom);
    idle(100);
    applyStimulus(24'd2097152, 5, $urandom);
    idle(20);

    $display("[TB] two radians per tick with wrap");
    doReset();
    repeat (4) begin
      applyStimulus(24'd4194304, 4, $urandom);
      idle(12);
    end

    $display("[TB] long sin latency");
    applyStimulus(24'd12345, 38, 32'h3F000000);
    idle(45);
    checkOutput("lfo_out held", lfoOut, 32'h3F000000);

    $display("[TB] tick during WAIT");
    doReset();
    applyStimulus(24'd300000, 20, $urandom);
    idle(6);
    applyStimulus(24'd300000, 20, $urandom);
    idle(30);
    applyStimulus(24'd300000, 4, $urandom);
    idle(12);
    checkOutput("overrun after WAIT tick", {31'd0, overrun}, {31'd0, modelOverrun});

    $display("[TB] tick during OUTPUT");
    doReset();
    applyStimulus(24'd1000000, 6, $urandom);
    idle(7);
    applyStimulus(24'd1000000, 6, $urandom);
    idle(5);
    applyStimulus(24'd1000000, 6, $urandom);
    idle(12);
    checkOutput("overrun after OUTPUT tick", {31'd0, overrun}, 32'd1);

    $display("[TB] reset during WAIT");
    doReset();
    applyStimulus(24'd500000, 38, $urandom);
    idle(8);
    seenBefore = startSeen;
    doReset();
    idle(10);
    checkOutput("no start after reset", startSeen, seenBefore);
    checkOutput("busy after reset", {31'd0, busy}, 32'd0);
    applyStimulus(24'd500000, 3, $urandom);
    idle(10);

    $display("[TB] randomized ticks");
    doReset();
    for (int n = 0; n < 40; n++) begin
      rndInc = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 4194304));
      applyStimulus(rndInc, $urandom_range(1, 12), $urandom);
      idle($urandom_range(0, 20));
    end
    idle(20);
    checkOutput("overrun random", {31'd0, overrun}, {31'd0, modelOverrun});

`ifdef LFO_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    doReset();
    applyStimulus(24'd777, 0, 32'd0);
    idle(30);
    checkOutput("timeout_err early", {31'd0, timeoutErr}, 32'd0);
    idle(50);
    checkOutput("timeout_err", {31'd0, timeoutErr}, 32'd1);
    checkOutput("busy after timeout", {31'd0, busy}, 32'd0);
    checkOutput("lfo_out after timeout", lfoOut, 32'd0);
    applyStimulus(24'd777, 3, $urandom);
    idle(12);
`endif

    for (int w = 0; (w < 200) && ((expStartQ.size() + expValidQ.size()) > 0); w++) begin
      @(negedge clock);
    end
    checkOutput("pending sin_start", expStartQ.size(), 32'd0);
    checkOutput("pending lfo_valid", expValidQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
